// File: rtl/qpi_mi_arb.sv
// Round-robin arbiter sharing one QPI memory-controller command/data port between N requesters.
// One transaction in flight: owner holds the port from command accept until its last data beat.
module qpi_mi_arb #(
    parameter int N       = 2,
    parameter int AW      = 32,
    parameter int TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*AW-1:0] s_addr,
    input  logic [N*7-1:0]  s_len,
    input  logic [N-1:0]    s_rw,
    input  logic [N-1:0]    s_valid,
    output logic [N-1:0]    s_ready,
    input  logic [N*32-1:0] s_wdata,
    output logic [N-1:0]    s_wack,
    output logic [N-1:0]    s_wlast,
    output logic [31:0]     s_rdata,
    output logic [N-1:0]    s_rstb,
    output logic [N-1:0]    s_rlast,
    output logic [AW-1:0]   m_addr,
    output logic [6:0]      m_len,
    output logic            m_rw,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [31:0]     m_wdata,
    input  logic            m_wack,
    input  logic            m_wlast,
    input  logic [31:0]     m_rdata,
    input  logic            m_rstb,
    input  logic            m_rlast,
    output logic [2:0]      owner,
    output logic            busy,
    output logic            err_stb
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t         st;
    logic [IW-1:0]  own;
    logic [IW-1:0]  rr;
    logic           rw_q;
    logic [7:0]     cnt;
    logic [15:0]    tcnt;

    logic [AW-1:0]  addr_a  [N];
    logic [6:0]     len_a   [N];
    logic [31:0]    wdata_a [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign addr_a[i]  = s_addr[i*AW +: AW];
        assign len_a[i]   = s_len[i*7 +: 7];
        assign wdata_a[i] = s_wdata[i*32 +: 32];
    end

    // Next owner: first requester at or after rr+1, wrapping; lowest distance wins.
    logic [IW-1:0] pick;
    logic [IW:0]   idx;
    always_comb begin
        pick = rr;
        idx  = '0;
        for (int k = N; k >= 1; k--) begin
            idx = {1'b0, rr} + (IW+1)'(k);
            if (idx >= (IW+1)'(N))
                idx = idx - (IW+1)'(N);
            if (s_valid[idx[IW-1:0]])
                pick = idx[IW-1:0];
        end
    end

    logic beat;
    logic last;
    assign beat = (st == DATA) && (rw_q ? m_rstb : m_wack);
    assign last = beat && (rw_q ? m_rlast : m_wlast);

    always_comb begin
        m_valid = (st == CMD) && s_valid[own];
        m_addr  = (st == CMD) ? addr_a[own] : '0;
        m_len   = (st == CMD) ? len_a[own] : '0;
        m_rw    = (st == CMD) ? s_rw[own] : 1'b0;
        m_wdata = (st == DATA) ? wdata_a[own] : '0;
        s_rdata = m_rdata;
        s_ready = '0;
        s_wack  = '0;
        s_wlast = '0;
        s_rstb  = '0;
        s_rlast = '0;
        for (int i = 0; i < N; i++) begin
            if (own == IW'(i)) begin
                s_ready[i] = m_valid && m_ready;
                s_wack[i]  = (st == DATA) && m_wack;
                s_wlast[i] = (st == DATA) && m_wlast;
                s_rstb[i]  = (st == DATA) && m_rstb;
                s_rlast[i] = (st == DATA) && m_rlast;
            end
        end
    end

    assign owner = 3'(own);
    assign busy  = (st != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            own     <= IW'(N-1);
            rr      <= IW'(N-1);
            rw_q    <= 1'b0;
            cnt     <= '0;
            tcnt    <= '0;
            err_stb <= 1'b0;
        end else begin
            err_stb <= 1'b0;
            case (st)
                IDLE: begin
                    if (|s_valid) begin
                        own <= pick;
                        st  <= CMD;
                    end
                end
                CMD: begin
                    if (m_valid && m_ready) begin
                        st   <= DATA;
                        rw_q <= s_rw[own];
                        cnt  <= 8'(len_a[own]) + 8'd1;
                        tcnt <= '0;
                    end else if (!s_valid[own]) begin
                        // Requester withdrew before accept: abort, keep its priority.
                        st      <= IDLE;
                        err_stb <= 1'b1;
                    end
                end
                DATA: begin
                    if (beat) begin
                        cnt  <= (cnt != 8'd0) ? cnt - 8'd1 : 8'd0;
                        tcnt <= '0;
                        if ((last && cnt != 8'd1) || (!last && cnt <= 8'd1))
                            err_stb <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                    if (last) begin
                        st <= IDLE;
                        rr <= own;
                    end else if (TIMEOUT > 0 && !beat && tcnt == 16'(TIMEOUT-1)) begin
                        st      <= IDLE;
                        rr      <= own;
                        err_stb <= 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
